sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, SRAM address width.
REQ-002 SHALL have parameter DW, default 8, SRAM data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req_a/req_b  input  1  access request from requester A/B.
REQ-006 SHALL have ports we_a/we_b  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr_a/addr_b  input  AW  and wdata_a/wdata_b  input  DW  command fields.
REQ-008 SHALL have ports gnt_a/gnt_b  output  1  one-cycle command-accepted pulse.
REQ-009 SHALL have ports done_a/done_b  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  DW  read data, shared by both requesters.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have ports mem_cs, mem_wr, mem_rd  output  1 each, and mem_addr  output  AW, mem_din  output  DW  driving the SRAM.
REQ-013 SHALL have port mem_dout  input  DW  SRAM read data.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-015 At edge N in IDLE with any req high: pick a winner, latch its we/addr/wdata, enter SETUP.
- gnt_<winner> is high for the cycle after edge N.
- In IDLE with no req: stay in IDLE.
REQ-016 SETUP: mem_cs=1, mem_addr/mem_din = latched values, mem_wr=mem_rd=0.
REQ-017 ACCESS: mem_cs=1 and mem_wr=we, mem_rd=!we; addr/din held stable.
REQ-018 At edge entering DONE, a read SHALL register mem_dout into rdata.
- A write SHALL leave rdata unchanged.
REQ-019 DONE: mem_cs=mem_wr=mem_rd=0; done_<winner>=1 for that cycle only.
REQ-020 Latency: req sampled at edge N -> rdata valid and done at cycle after edge N+2; next grant no earlier than edge N+3.
REQ-021 Commands are latched at grant; req/fields changing after gnt SHALL NOT affect the transaction.
REQ-022 Requests arriving while busy SHALL be held off (no gnt) and arbitrated on the next IDLE sample.
REQ-023 Both req high in IDLE SHALL grant exactly one requester; the other keeps waiting.
REQ-024 Identical addresses from A and B SHALL be serialized in grant order; a read after a write returns the written data.
REQ-025 gnt_a and gnt_b SHALL never be high together; likewise done_a and done_b; mem_wr and mem_rd SHALL never be high together.

Reset
REQ-026 rst high at an edge SHALL force FSM to IDLE and all outputs to 0 (rdata=0) at that edge, regardless of state.
REQ-027 A transaction in progress at reset SHALL be abandoned with no done pulse.
REQ-028 Reset SHALL set the last-grant register to B.

Configuration
REQ-029 Macro SRAM_ARB_RR_EN defined: round-robin; on tie, grant the requester not granted last; last-grant updates on every grant.
REQ-030 Macro SRAM_ARB_RR_EN undefined: fixed priority, A always wins ties; last-grant register absent.

Structure
REQ-031 Shared package sram_arb_pkg SHALL hold FSM state encodings (IDLE=0, SETUP=1, ACCESS=2, DONE=3) and default AW/DW constants.
REQ-032 Winner selection SHALL live in sub-module sram_arb_pick (inputs req_a, req_b, last_grant; output winner id and valid).

Verification
REQ-033 Single write A: addr 0x0F, wdata 0xAA -> gnt_a next cycle; mem_wr high one cycle with mem_addr=0x0F, mem_din=0xAA; done_a two cycles after gnt_a.
REQ-034 Read-back B: addr 0x0F after REQ-033 -> mem_rd one cycle; rdata=0xAA with done_b.
REQ-035 Both req held continuously (RR_EN): grants alternate A,B,A,B, one per 4 cycles. Without RR_EN: A only while req_a held.
REQ-036 req_b asserted during A's ACCESS -> no gnt_b until FSM returns to IDLE; then gnt_b.
REQ-037 rst pulsed during ACCESS -> next cycle all outputs 0, FSM IDLE, no done; a following request completes normally.
REQ-038 Monitor every cycle: no simultaneous gnt_a/gnt_b, done_a/done_b or mem_wr/mem_rd; mem_cs low in IDLE and DONE.

Source files
------------

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared constants for the two-port SRAM arbiter (FSM encodings,
//            requester ids, default address/data widths).
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

    localparam int c_default_aw = 8;
    localparam int c_default_dw = 8;
    localparam int c_state_w    = 2;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_setup  = 2'd1;
    localparam state_t c_st_access = 2'd2;
    localparam state_t c_st_done   = 2'd3;

    typedef logic req_id_t;

    localparam req_id_t c_id_a = 1'b0;
    localparam req_id_t c_id_b = 1'b1;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pick
// Brief    : Winner selection; on a tie the requester not granted last wins.
// Revision : 1.0
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_grant,
    output req_id_t winner,
    output logic    valid
);

    always_comb begin
        valid  = req_a | req_b;
        winner = c_id_a;
        if (req_a && req_b) begin
            winner = other_id(last_grant);
        end else if (req_b) begin
            winner = c_id_b;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-requester single-port SRAM arbiter, IDLE/SETUP/ACCESS/DONE.
//            Define SRAM_ARB_RR_EN for round-robin ties; otherwise A wins ties.
// Revision : 1.0
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = c_default_aw,
    parameter int DW = c_default_dw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_cs,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        r_state_q,  w_state_d;
    req_id_t       r_winner_q, w_winner_d;
    logic          r_we_q,     w_we_d;
    logic [AW-1:0] r_addr_q,   w_addr_d;
    logic [DW-1:0] r_wdata_q,  w_wdata_d;
    logic [DW-1:0] r_rdata_q,  w_rdata_d;

    req_id_t       w_last_grant;
    req_id_t       w_pick_winner;
    logic          w_pick_valid;

    sram_arb_pick u_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (w_last_grant),
        .winner     (w_pick_winner),
        .valid      (w_pick_valid)
    );

`ifdef SRAM_ARB_RR_EN
    req_id_t r_last_q, w_last_d;

    always_comb begin
        w_last_d = r_last_q;
        if (r_state_q == c_st_idle && w_pick_valid) begin
            w_last_d = w_pick_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_q <= c_id_b;
        end else begin
            r_last_q <= w_last_d;
        end
    end

    assign w_last_grant = r_last_q;
`else
    // Pinning "last" to B makes the picker's tie rule collapse to A-first.
    assign w_last_grant = c_id_b;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_st_idle;
            r_winner_q <= c_id_a;
            r_we_q     <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_rdata_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_winner_q <= w_winner_d;
            r_we_q     <= w_we_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    // Next state and command latching
    always_comb begin
        w_state_d  = r_state_q;
        w_winner_d = r_winner_q;
        w_we_d     = r_we_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_rdata_d  = r_rdata_q;
        case (r_state_q)
            c_st_idle: begin
                if (w_pick_valid) begin
                    w_state_d  = c_st_setup;
                    w_winner_d = w_pick_winner;
                    w_we_d     = (w_pick_winner == c_id_b) ? we_b    : we_a;
                    w_addr_d   = (w_pick_winner == c_id_b) ? addr_b  : addr_a;
                    w_wdata_d  = (w_pick_winner == c_id_b) ? wdata_b : wdata_a;
                end
            end
            c_st_setup:  w_state_d = c_st_access;
            c_st_access: begin
                w_state_d = c_st_done;
                if (!r_we_q) begin
                    w_rdata_d = mem_dout;
                end
            end
            c_st_done:   w_state_d = c_st_idle;
            default:     w_state_d = c_st_idle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        mem_cs   = 1'b0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        busy     = (r_state_q != c_st_idle);
        case (r_state_q)
            c_st_setup: begin
                gnt_a    = (r_winner_q == c_id_a);
                gnt_b    = (r_winner_q == c_id_b);
                mem_cs   = 1'b1;
                mem_addr = r_addr_q;
                mem_din  = r_wdata_q;
            end
            c_st_access: begin
                mem_cs   = 1'b1;
                mem_wr   = r_we_q;
                mem_rd   = !r_we_q;
                mem_addr = r_addr_q;
                mem_din  = r_wdata_q;
            end
            c_st_done: begin
                done_a = (r_winner_q == c_id_a);
                done_b = (r_winner_q == c_id_b);
            end
            default: ;
        endcase
    end

    assign rdata = r_rdata_q;

endmodule
`default_nettype wire
